// File: rtl/dp_control_fsm.sv
// dp_control_fsm: Moore control unit for the 8-bit summation datapath.
// Computes SUM = n + (n-1) + ... + 1 by sequencing the datapath muxes and
// register loads. It talks to the host over a four-phase start/done handshake.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   start     host request (level, four-phase)
//   cnt_zero  datapath status: count register == 0
//   cnt_sel   count mux: 1 = external n, 0 = decremented count
//   cnt_load  count register load enable
//   sum_sel   sum mux: 1 = constant 0, 0 = adder output (sum + cnt)
//   sum_load  sum register load enable
//   out_en    drive the sum register onto the output bus
//   busy      run in progress
//   done      result valid / handshake acknowledge
//   err       run aborted by the iteration limit
//
// Optional feature: define CU_TIMEOUT_EN to add an ITER_W-bit loop counter.
// When it is enabled, a run is forced to OUT with err=1 after MAX_ITER loop
// passes without cnt_zero. Without it, err is tied to 0 and ITER_W and
// MAX_ITER are unused.
`timescale 1ns / 1ps

module dp_control_fsm #(
  parameter int unsigned ITER_W   = 8,
  parameter int unsigned MAX_ITER = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic cnt_zero,
  output logic cnt_sel,
  output logic cnt_load,
  output logic sum_sel,
  output logic sum_load,
  output logic out_en,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StInit = 3'd1,
    StTest = 3'd2,
    StLoop = 3'd3,
    StOut  = 3'd4
  } state_e;

  // Plain vector so that the unused codes 5-7 can be represented and recovered from.
  logic [2:0] state_q, state_d;
  logic       timeout_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle: state_d = start ? StInit : StIdle;
      StInit: state_d = StTest;
      StTest: begin
        if (cnt_zero || timeout_hit) begin
          state_d = StOut;
        end else begin
          state_d = StLoop;
        end
      end
      StLoop: state_d = StTest;
      StOut:  state_d = start ? StOut : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs. Codes 5-7 fall through to the all-zero defaults.
  always_comb begin
    cnt_sel  = 1'b0;
    cnt_load = 1'b0;
    sum_sel  = 1'b0;
    sum_load = 1'b0;
    out_en   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      StInit: begin
        cnt_sel  = 1'b1;
        cnt_load = 1'b1;
        sum_sel  = 1'b1;
        sum_load = 1'b1;
        busy     = 1'b1;
      end
      StTest: busy = 1'b1;
      StLoop: begin
        // sum_sel=0 / cnt_sel=0: sum += cnt and cnt -= 1 on the same edge
        cnt_load = 1'b1;
        sum_load = 1'b1;
        busy     = 1'b1;
      end
      StOut: begin
        out_en = 1'b1;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CU_TIMEOUT_EN
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              err_q, err_d;

  assign timeout_hit = (iter_q == ITER_W'(MAX_ITER));

  always_comb begin
    iter_d = iter_q;
    err_d  = err_q;
    case (state_q)
      StInit: begin
        iter_d = '0;
        err_d  = 1'b0;
      end
      StLoop: iter_d = iter_q + 1'b1;
      // Only flag an abort; a genuine zero on the limit pass is a normal finish.
      StTest: if (!cnt_zero && timeout_hit) err_d = 1'b1;
      StOut:  if (!start) err_d = 1'b0;
      default: err_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter_q <= '0;
      err_q  <= 1'b0;
    end else begin
      iter_q <= iter_d;
      err_q  <= err_d;
    end
  end

  // Qualified by state so err stays a pure decode of OUT.
  assign err = err_q && (state_q == StOut);
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
  assign unused_cfg  = ^{ITER_W, MAX_ITER};
`endif

endmodule

// File: tb/tb_dp_control_fsm.sv
// Self-checking bench for dp_control_fsm. It contains a small datapath model
// (count/sum registers) driven by the DUT's control outputs. Expected traces
// and results are derived from the arithmetic of the summation.
`timescale 1ns / 1ps

module tb_dp_control_fsm;

`ifdef CU_TIMEOUT_EN
  localparam int DutMaxIter   = 4;
  localparam int ModelMaxIter = 4;
`else
  localparam int DutMaxIter   = 255;
  localparam int ModelMaxIter = 1 << 20;
`endif

  // {cnt_sel, cnt_load, sum_sel, sum_load, out_en, busy, done, err}
  localparam logic [7:0] PIdle = 8'b0000_0000;
  localparam logic [7:0] PInit = 8'b1111_0100;
  localparam logic [7:0] PTest = 8'b0000_0100;
  localparam logic [7:0] PLoop = 8'b0101_0100;
  localparam logic [7:0] POut  = 8'b0000_1010;

  logic clk, reset, start, cnt_zero;
  logic cnt_sel, cnt_load, sum_sel, sum_load, out_en, busy, done, err;

  logic [7:0] n_val, cnt_r, sum_r, sum_bus;
  logic       stuck_nz;

  int errors = 0;
  int checks = 0;

  dp_control_fsm #(
    .ITER_W  (8),
    .MAX_ITER(DutMaxIter)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .cnt_zero(cnt_zero),
    .cnt_sel (cnt_sel),
    .cnt_load(cnt_load),
    .sum_sel (sum_sel),
    .sum_load(sum_load),
    .out_en  (out_en),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model
  assign cnt_zero = !stuck_nz && (cnt_r == 8'd0);
  assign sum_bus  = out_en ? sum_r : 8'd0;

  always @(posedge clk) begin
    if (cnt_load) cnt_r <= cnt_sel ? n_val : cnt_r - 8'd1;
    if (sum_load) sum_r <= sum_sel ? 8'd0 : sum_r + cnt_r;
  end

  function automatic logic [7:0] outs();
    return {cnt_sel, cnt_load, sum_sel, sum_load, out_en, busy, done, err};
  endfunction

  function automatic bit check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One complete run. Every cycle is compared against the expected phase
  // sequence INIT, TEST, (LOOP, TEST) x loops, OUT.
  task automatic run(input int n, input bit drop_early, input bit reraise,
                     output int edges, output int sum_o, output bit err_o);
    logic [7:0] q[$];
    logic [7:0] exp_p;
    logic [7:0] out_p;
    int         loops;
    bit         bad;
    loops = (n > ModelMaxIter) ? ModelMaxIter : n;
    q.push_back(PInit);
    q.push_back(PTest);
    for (int i = 0; i < loops; i++) begin
      q.push_back(PLoop);
      q.push_back(PTest);
    end
    out_p = POut | ((n > loops || stuck_nz) ? 8'h01 : 8'h00);
    q.push_back(out_p);
    @(negedge clk);
    n_val = 8'(n);
    start = 1'b1;
    edges = 0;
    bad   = 1'b0;
    while (!bad && q.size() > 0) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (drop_early && edges == 1) start = 1'b0;
      exp_p = q.pop_front();
      if (!check($sformatf("trace n=%0d edge=%0d", n, edges), outs(), exp_p)) bad = 1'b1;
    end
    sum_o = sum_bus;
    err_o = err;
    if (bad) begin
      pulse_reset();
      return;
    end
    if (reraise) start = 1'b1;
    // Holding start keeps OUT; it never retriggers a run.
    if (start) begin
      repeat (2) begin
        @(negedge clk);
        void'(check("out_hold", outs(), out_p));
      end
    end
    start = 1'b0;
    @(negedge clk);
    void'(check("out_exit", outs(), PIdle));
    @(negedge clk);
    void'(check("idle_stay", outs(), PIdle));
  endtask

  typedef struct {
    int n;
    bit drop_early;
    bit reraise;
    int exp_edges;
    int exp_sum;
    bit exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int  edges, sum_o, n, loops, found;
    bit  err_o, drop, rer;

`ifdef CU_TIMEOUT_EN
    tbl[0] = '{0, 1'b0, 1'b0, 3, 0, 1'b0};
    tbl[1] = '{3, 1'b0, 1'b0, 9, 6, 1'b0};
    tbl[2] = '{4, 1'b1, 1'b1, 11, 10, 1'b0};
    tbl[3] = '{5, 1'b0, 1'b0, 11, 14, 1'b1};
    tbl[4] = '{7, 1'b1, 1'b0, 11, 22, 1'b1};
    tbl[5] = '{1, 1'b0, 1'b1, 5, 1, 1'b0};
`else
    tbl[0] = '{0, 1'b0, 1'b0, 3, 0, 1'b0};
    tbl[1] = '{5, 1'b0, 1'b0, 13, 15, 1'b0};
    tbl[2] = '{5, 1'b1, 1'b1, 13, 15, 1'b0};
    tbl[3] = '{1, 1'b1, 1'b0, 5, 1, 1'b0};
    tbl[4] = '{22, 1'b0, 1'b0, 47, 253, 1'b0};
    tbl[5] = '{23, 1'b0, 1'b1, 49, 20, 1'b0};
`endif

    reset    = 1'b0;
    start    = 1'b0;
    stuck_nz = 1'b0;
    n_val    = 8'd0;
    #12;
    void'(check("reset_outputs", outs(), PIdle));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    void'(check("idle_after_reset", outs(), PIdle));

    // Table-driven runs
    foreach (tbl[i]) begin
      run(tbl[i].n, tbl[i].drop_early, tbl[i].reraise, edges, sum_o, err_o);
      void'(check($sformatf("tbl%0d_edges", i), edges, tbl[i].exp_edges));
      void'(check($sformatf("tbl%0d_sum", i), sum_o, tbl[i].exp_sum));
      void'(check($sformatf("tbl%0d_err", i), int'(err_o), int'(tbl[i].exp_err)));
    end

    // Async reset in the middle of a LOOP cycle
    @(negedge clk);
    n_val = 8'd5;
    start = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk);
      if (outs() == PLoop) found = 1;
    end
    void'(check("reached_loop", found, 1));
    #2 reset = 1'b0;
    #1 void'(check("async_reset_outputs", outs(), PIdle));
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      void'(check($sformatf("post_reset_idle%0d", c), outs(), PIdle));
    end

    // Illegal state code recovers to IDLE, not straight to INIT
    @(negedge clk);
    force dut.state_q = 3'd6;
    #1 release dut.state_q;
    void'(check("illegal_outputs", outs(), PIdle));
    start = 1'b1;
    @(negedge clk);
    void'(check("illegal_to_idle", outs(), PIdle));
    @(negedge clk);
    void'(check("idle_then_init", outs(), PInit));
    pulse_reset();

`ifdef CU_TIMEOUT_EN
    // Stuck cnt_zero: the limit aborts after MAX_ITER loop passes
    stuck_nz = 1'b1;
    run(200, 1'b0, 1'b0, edges, sum_o, err_o);
    void'(check("timeout_edges", edges, 2 * ModelMaxIter + 3));
    void'(check("timeout_err", int'(err_o), 1));
    stuck_nz = 1'b0;
`endif

    // Randomized runs against the arithmetic model
    for (int r = 0; r < 25; r++) begin
      n     = int'($urandom_range(0, 40));
      drop  = 1'($urandom_range(0, 1));
      rer   = 1'($urandom_range(0, 1));
      loops = (n > ModelMaxIter) ? ModelMaxIter : n;
      run(n, drop, rer, edges, sum_o, err_o);
      void'(check($sformatf("rand%0d_edges n=%0d", r, n), edges, 2 * loops + 3));
      void'(check($sformatf("rand%0d_sum n=%0d", r, n), sum_o,
                  ((loops * (2 * n - loops + 1)) / 2) % 256));
      void'(check($sformatf("rand%0d_err n=%0d", r, n), int'(err_o), (n > loops) ? 1 : 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
